beat_sequencer: RTL

//   Timing generator for the hardwired controller. Produces the one-hot beat

---
 rtl/hdcpu_pkg.sv | 40 ++++
 rtl/start_sync.sv | 47 ++++
 rtl/beat_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/hdcpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : hdcpu_pkg                                                     |
// | Description: Shared beat encodings, sequencer state type and defaults for  |
// |              the hardwired controller timing logic.                        |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package hdcpu_pkg;

    localparam int PHASES_DEF      = 3;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 16;

    localparam logic [2:0] W_B1 = 3'b001;
    localparam logic [2:0] W_B2 = 3'b010;
    localparam logic [2:0] W_B3 = 3'b100;

    typedef enum logic [0:0] {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // SHORT dominates LONG; anything unexpected falls back to W1 to stay one-hot.
    function automatic logic [2:0] next_beat(
        input logic [2:0] cur,
        input logic       req_short,
        input logic       req_long
    );
        logic [2:0] nb;
        nb = W_B1;
        case (cur)
            W_B1:    nb = req_short ? W_B1 : W_B2;
            W_B2:    nb = req_short ? W_B1 : (req_long ? W_B3 : W_B1);
            default: nb = W_B1;
        endcase
        return nb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/start_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : start_sync                                                    |
// | Description: Multi-flop synchronizer plus rising-edge pulse for the panel  |
// |              START button. Needs a genuine low level after reset to arm.   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module start_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   r_armed;
    logic                   w_level;
    logic                   w_valid;

    assign w_level = r_sync[SYNC_STAGES-1];
    assign w_valid = r_fill[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev <= w_level;
            // A button held through reset must be seen released before it counts.
            if (w_valid && !w_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_pulse = w_valid & r_armed & w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/beat_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : beat_sequencer                                                |
// | Description: One-hot beat / T3 timing generator with START-driven run and  |
// |              halt control. BEAT_SINGLE_STEP_EN adds the SSTEP input.       |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module beat_sequencer
    import hdcpu_pkg::*;
#(
    parameter int PHASES      = PHASES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
`ifdef BEAT_SINGLE_STEP_EN
    input  logic             SSTEP,
`endif
    output logic [3:1]       W,
    output logic             T3,
    output logic             RUN,
    output logic [CNT_W-1:0] CYC
);

    localparam int                c_PH_W    = $clog2(PHASES);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(PHASES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_PH_W-1:0]  r_phase;
    logic [c_PH_W-1:0]  w_phase_nxt;
    logic [2:0]         r_w;
    logic [2:0]         w_w_nxt;
    logic               r_t3;
    logic               w_t3_nxt;
    logic [CNT_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   w_cyc_nxt;
    logic               w_stp;
    logic               w_halt_req;

    start_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_start_sync (
        .clk     (CLK),
        .rst     (RST),
        .i_async (START),
        .o_pulse (w_stp)
    );

`ifdef BEAT_SINGLE_STEP_EN
    assign w_halt_req = STOP | SSTEP;
`else
    assign w_halt_req = STOP;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_w_nxt     = r_w;
        w_cyc_nxt   = r_cyc;
        case (r_state)
            ST_HALT: begin
                if (w_stp) begin
                    w_state_nxt = ST_RUN;
                    w_phase_nxt = '0;
                end
            end
            ST_RUN: begin
                if (r_phase == c_PH_LAST) begin
                    // Beat boundary: controller requests are only honoured here.
                    w_w_nxt     = next_beat(r_w, SHORT, LONG);
                    w_phase_nxt = '0;
                    if (w_w_nxt == W_B1) begin
                        w_cyc_nxt = r_cyc + CNT_W'(1);
                    end
                    if (w_halt_req) begin
                        w_state_nxt = ST_HALT;
                    end
                end else begin
                    w_phase_nxt = r_phase + c_PH_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
                w_phase_nxt = '0;
                w_w_nxt     = W_B1;
            end
        endcase
        w_t3_nxt = (w_state_nxt == ST_RUN) && (w_phase_nxt == c_PH_LAST);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_HALT;
            r_phase <= '0;
            r_w     <= W_B1;
            r_t3    <= 1'b0;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_w     <= w_w_nxt;
            r_t3    <= w_t3_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    assign W   = r_w;
    assign T3  = r_t3;
    assign RUN = (r_state == ST_RUN);
    assign CYC = r_cyc;

endmodule
`default_nettype wire
